// File: rtl/polar_result_fifo.sv
// polar_result_fifo
//   Capture stage for the CORDIC rectangular-to-polar converter. Every cycle
//   in which the converter strobes i_aux under i_ce, one magnitude/phase pair
//   is written into a small first-word-fall-through FIFO. A consumer drains it
//   through a valid/ready handshake. Samples that arrive while the FIFO is
//   full and not being drained are dropped: this sets a sticky overflow flag
//   and bumps a saturating 16-bit drop counter.
//
// Ports
//   i_clk, i_reset_n     clock (rising edge), asynchronous active-low reset
//   i_ce, i_aux          write strobe = i_ce & i_aux
//   i_mag, i_phase       sample written on an accepted push
//   i_clr                synchronous flush; clears pointers, level and status
//   i_ready              consumer ready
//   o_valid              head entry available
//   o_mag, o_phase       head entry, combinational; 0 when empty
//   o_level              occupancy 0..DEPTH
//   o_full, o_empty      occupancy flags
//   o_overflow           sticky, a sample was dropped
//   o_drop_count         number of dropped samples, saturating at 16'hFFFF
module polar_result_fifo #(
  parameter int MAG_W = 12,
  parameter int PH_W  = 19,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic             i_aux,
  input  logic [MAG_W-1:0] i_mag,
  input  logic [PH_W-1:0]  i_phase,
  input  logic             i_clr,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [MAG_W-1:0] o_mag,
  output logic [PH_W-1:0]  o_phase,
  output logic [AW:0]      o_level,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow,
  output logic [15:0]      o_drop_count
);

  localparam int DW = MAG_W + PH_W;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   level;
  logic          overflow;
  logic [15:0]   drop_count;

  logic          push_req;
  logic          pop;
  logic          push;
  logic          drop;
  logic [DW-1:0] head;

  assign o_valid = (level != '0);
  assign o_empty = (level == '0);
  assign o_full  = (level == FULL_LEVEL);

  assign push_req = i_ce & i_aux;
  assign pop      = o_valid & i_ready;
  // A pop in the same cycle frees the slot the push will occupy, so a full
  // FIFO that is being drained still accepts the incoming sample.
  assign push     = push_req & (~o_full | pop);
  assign drop     = push_req & o_full & ~pop;

  assign head    = mem[rd_ptr];
  assign o_mag   = o_valid ? head[DW-1:PH_W] : '0;
  assign o_phase = o_valid ? head[PH_W-1:0]  : '0;

  assign o_level      = level;
  assign o_overflow   = overflow;
  assign o_drop_count = drop_count;

  // Storage is deliberately not reset; pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (push && !i_clr) begin
      mem[wr_ptr] <= {i_mag, i_phase};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (i_clr) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !push) begin
        level <= level - (AW+1)'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_polar_result_fifo.sv
module tb_polar_result_fifo;

  localparam int MAG_W = 12;
  localparam int PH_W  = 19;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             i_clk;
  logic             i_reset_n;
  logic             i_ce;
  logic             i_aux;
  logic [MAG_W-1:0] i_mag;
  logic [PH_W-1:0]  i_phase;
  logic             i_clr;
  logic             i_ready;
  logic             o_valid;
  logic [MAG_W-1:0] o_mag;
  logic [PH_W-1:0]  o_phase;
  logic [AW:0]      o_level;
  logic             o_full;
  logic             o_empty;
  logic             o_overflow;
  logic [15:0]      o_drop_count;

  polar_result_fifo #(
    .MAG_W(MAG_W),
    .PH_W (PH_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_ce        (i_ce),
    .i_aux       (i_aux),
    .i_mag       (i_mag),
    .i_phase     (i_phase),
    .i_clr       (i_clr),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_mag       (o_mag),
    .o_phase     (o_phase),
    .o_level     (o_level),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_overflow  (o_overflow),
    .o_drop_count(o_drop_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: a queue of {mag, phase} entries plus status.
  typedef struct {
    int unsigned mag;
    int unsigned ph;
  } sample_t;

  sample_t     q[$];
  bit          m_ovf;
  int unsigned m_drops;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
  endtask

  // Applies the inputs present at the rising edge to the model.
  task automatic model_edge();
    bit req, pop, full, push, drop;
    sample_t s;
    if (i_clr) begin
      model_reset();
    end else begin
      req  = i_ce && i_aux;
      pop  = (q.size() > 0) && i_ready;
      full = (q.size() == DEPTH);
      push = req && (!full || pop);
      drop = req && full && !pop;
      if (pop) void'(q.pop_front());
      if (push) begin
        s.mag = int'(i_mag);
        s.ph  = int'(i_phase);
        q.push_back(s);
      end
      if (drop) begin
        m_ovf = 1'b1;
        if (m_drops < 32'hFFFF) m_drops++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned em, ep;
    em = (q.size() > 0) ? q[0].mag : 0;
    ep = (q.size() > 0) ? q[0].ph  : 0;
    check({tag, ".valid"}, 32'(o_valid), 32'(q.size() > 0));
    check({tag, ".mag"},   32'(o_mag),   em);
    check({tag, ".phase"}, 32'(o_phase), ep);
    check({tag, ".level"}, 32'(o_level), q.size());
    check({tag, ".full"},  32'(o_full),  32'(q.size() == DEPTH));
    check({tag, ".empty"}, 32'(o_empty), 32'(q.size() == 0));
    check({tag, ".ovf"},   32'(o_overflow), 32'(m_ovf));
    check({tag, ".drops"}, 32'(o_drop_count), m_drops);
  endtask

  task automatic drive(input bit ce, input bit aux, input int unsigned mag,
                       input int unsigned ph, input bit clr, input bit rdy);
    i_ce    = ce;
    i_aux   = aux;
    i_mag   = MAG_W'(mag);
    i_phase = PH_W'(ph);
    i_clr   = clr;
    i_ready = rdy;
  endtask

  // One clock: inputs already driven; model follows the edge; check on negedge.
  task automatic step(input string tag);
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    check_all(tag);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    i_reset_n = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Single push, then held with consumer stalled.
    drive(1, 1, 1, 32'h0A000, 0, 0);
    step("t1_push");
    check("t1_mag", 32'(o_mag), 1);
    check("t1_phase", 32'(o_phase), 32'h0A000);
    check("t1_level", 32'(o_level), 1);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step("t1_hold");
    check("t1_mag_held", 32'(o_mag), 1);
    drive(0, 0, 0, 0, 0, 1);
    step("t1_drain");

    // Fill to 8, then overflow with a 9th; drain in order.
    for (int i = 1; i <= 9; i++) begin
      drive(1, 1, i, i * 3, 0, 0);
      step("t2_fill");
    end
    check("t2_full", 32'(o_full), 1);
    check("t2_level", 32'(o_level), 8);
    check("t2_ovf", 32'(o_overflow), 1);
    check("t2_drops", 32'(o_drop_count), 1);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      check("t2_order", 32'(o_mag), i);
      step("t2_drain");
    end
    check("t2_empty", 32'(o_empty), 1);

    // Full plus simultaneous pop: push accepted, no overflow.
    drive(0, 0, 0, 0, 1, 0);
    step("t3_clr");
    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 100 + i, i, 0, 0);
      step("t3_fill");
    end
    drive(1, 1, 20, 7, 0, 1);
    step("t3_pushpop");
    check("t3_level", 32'(o_level), 8);
    check("t3_ovf", 32'(o_overflow), 0);
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step("t3_drain");
    check("t3_last", 32'(o_mag), 20);
    step("t3_drain_last");

    // Streaming with consumer always ready.
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, i, i + 5, 0, 1);
      step("t4_stream");
      check("t4_mag", 32'(o_mag), i);
      check("t4_level_le1", 32'(o_level <= 1), 1);
    end
    drive(0, 0, 0, 0, 0, 1);
    step("t4_tail");

    // Strobe without clock enable writes nothing.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 55, 55, 0, 0);
      step("t5_noce");
      check("t5_level", 32'(o_level), 0);
    end
    // Full with three drops, then clear alongside a push.
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 200 + i, i, 0, 0);
      step("t5_fill");
    end
    check("t5_drops3", 32'(o_drop_count), 3);
    drive(1, 1, 999, 1, 1, 1);
    step("t5_clr");
    check("t5_clr_level", 32'(o_level), 0);
    check("t5_clr_ovf", 32'(o_overflow), 0);
    check("t5_clr_drops", 32'(o_drop_count), 0);

    // Asynchronous reset mid-drain at level 5.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 300 + i, i, 0, 0);
      step("t6_fill");
    end
    drive(0, 0, 0, 0, 0, 1);
    step("t6_drain");
    drive(1, 1, 310, 0, 0, 0);
    step("t6_refill");
    check("t6_level5", 32'(o_level), 5);
    drive(0, 0, 0, 0, 0, 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check("t6_valid", 32'(o_valid), 0);
    check("t6_level", 32'(o_level), 0);
    check("t6_mag", 32'(o_mag), 0);
    check_all("t6_async");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    check_all("t6_release");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
            $urandom, $urandom, $urandom_range(63, 0) == 0,
            $urandom_range(2, 0) != 0 || (i % 400) > 300 ? ((i % 400) <= 300) : 1'b0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
